iopmp_dma_master: RTL

// - Register-programmed word-copy DMA engine: moves LEN 32-bit words from SRC to DST.
// - Its master port drives the core0_ex-side request bus that feeds the IOPMP filter, so all DMA traffic is permission-checked.
// - Its slave port sits on the peripheral register bus; it raises a level interrupt on completion.

---
 rtl/iopmp_dma_master_pkg.sv | 31 +++
 rtl/iopmp_dma_master.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/iopmp_dma_master_pkg.sv
// Shared definitions for the word-copy DMA master: register map, FSM encodings
// and CTRL/STATUS/CLR bit positions.
package iopmp_dma_master_pkg;

    localparam logic [2:0] DmaSrc    = 3'd0;
    localparam logic [2:0] DmaDst    = 3'd1;
    localparam logic [2:0] DmaLen    = 3'd2;
    localparam logic [2:0] DmaCtrl   = 3'd3;
    localparam logic [2:0] DmaStatus = 3'd4;
    localparam logic [2:0] DmaClr    = 3'd5;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;

    localparam int CtrlStart = 0;
    localparam int CtrlIrqEn = 1;
    localparam int CtrlAbort = 2;

    localparam int StatBusy = 0;
    localparam int StatDone = 1;
    localparam int StatErr  = 2;

    localparam int ClrDone = 1;
    localparam int ClrErr  = 2;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/iopmp_dma_master.sv
// Register-programmed word-copy DMA engine. Every beat goes out on the master
// bus that feeds the IOPMP filter; a level interrupt reports DONE/ERR.
module iopmp_dma_master
    import iopmp_dma_master_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [31:0] mst_addr_o,
    input  logic [31:0] mst_data_i,
    output logic [31:0] mst_data_o,
    output logic        mst_req_o,
    output logic        mst_we_o,
    input  logic        mst_gnt_i,
    input  logic        mst_err_i,
    output logic        irq_o,
    output logic [1:0]  dbg_state_o
);

    // Master handshake: a beat completes on the edge where mst_req_o and
    // mst_gnt_i are both high and mst_err_i is low; while mst_gnt_i is low the
    // request, address and write data are held unchanged. mst_err_i ends the
    // transfer and wins over mst_gnt_i.

    logic [2:0]       reg_sel;
    logic             wr_src, wr_dst, wr_len, wr_ctrl, wr_clr;
    logic             start_pulse, abort_pulse, abort_req;
    logic [31:0]      src_q, dst_q;
    logic [LEN_W-1:0] len_q;
    logic             irq_en_q;

    logic [1:0]       state;
    logic [31:0]      cur_src, cur_dst, buf_q;
    logic [LEN_W-1:0] cnt;
    logic             done_q, err_q, abort_q, irq_q;
    logic             unused_addr_bits;

    assign reg_sel          = addr_i[4:2];
    assign unused_addr_bits = ^{addr_i[31:5], addr_i[1:0]};

    assign wr_src      = we_i && (reg_sel == DmaSrc);
    assign wr_dst      = we_i && (reg_sel == DmaDst);
    assign wr_len      = we_i && (reg_sel == DmaLen);
    assign wr_ctrl     = we_i && (reg_sel == DmaCtrl);
    assign wr_clr      = we_i && (reg_sel == DmaClr);
    assign start_pulse = wr_ctrl && data_i[CtrlStart];
    assign abort_pulse = wr_ctrl && data_i[CtrlAbort];
    assign abort_req   = abort_q || abort_pulse;

    // Programming registers; the FSM works from its own latched copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
        end else begin
            if (wr_src)  src_q    <= word_align(data_i);
            if (wr_dst)  dst_q    <= word_align(data_i);
            if (wr_len)  len_q    <= data_i[LEN_W-1:0];
            if (wr_ctrl) irq_en_q <= data_i[CtrlIrqEn];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= StIdle;
            cur_src <= '0;
            cur_dst <= '0;
            buf_q   <= '0;
            cnt     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            irq_q <= irq_en_q && (done_q || err_q);
            // Clears come first so a status set in the same cycle wins.
            if (wr_clr && data_i[ClrDone]) done_q <= 1'b0;
            if (wr_clr && data_i[ClrErr])  err_q  <= 1'b0;
            case (state)
                StIdle: begin
                    abort_q <= 1'b0;
                    if (start_pulse) begin
                        if (len_q != '0) begin
                            cur_src <= src_q;
                            cur_dst <= dst_q;
                            cnt     <= len_q;
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                            state   <= StRd;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                StRd: begin
                    abort_q <= abort_req;
                    if (mst_err_i) begin
                        err_q <= 1'b1;
                        state <= StIdle;
                    end else if (mst_gnt_i) begin
                        buf_q   <= mst_data_i;
                        cur_src <= cur_src + 32'd4;
                        state   <= abort_req ? StIdle : StWr;
                    end
                end
                StWr: begin
                    abort_q <= abort_req;
                    if (mst_err_i) begin
                        err_q <= 1'b1;
                        state <= StIdle;
                    end else if (mst_gnt_i) begin
                        cur_dst <= cur_dst + 32'd4;
                        cnt     <= cnt - LEN_W'(1);
                        if (cnt == LEN_W'(1)) begin
                            done_q <= 1'b1;
                            state  <= StIdle;
                        end else begin
                            state <= abort_req ? StIdle : StRd;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    always_comb begin
        mst_req_o  = 1'b0;
        mst_we_o   = 1'b0;
        mst_addr_o = '0;
        mst_data_o = '0;
        case (state)
            StRd: begin
                mst_req_o  = 1'b1;
                mst_addr_o = cur_src;
            end
            StWr: begin
                mst_req_o  = 1'b1;
                mst_we_o   = 1'b1;
                mst_addr_o = cur_dst;
                mst_data_o = buf_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        data_o = '0;
        case (reg_sel)
            DmaSrc:    data_o = src_q;
            DmaDst:    data_o = dst_q;
            DmaLen:    data_o = 32'(len_q);
            DmaCtrl:   data_o[CtrlIrqEn] = irq_en_q;
            DmaStatus: begin
                data_o[31:16]    = 16'(cnt);
                data_o[StatBusy] = (state != StIdle);
                data_o[StatDone] = done_q;
                data_o[StatErr]  = err_q;
            end
            default: data_o = '0;
        endcase
    end

    assign irq_o       = irq_q;
    assign dbg_state_o = state;

endmodule
